sram_port_arbiter: RTL and testbench

- Shares one SRAM port (ram-wrapper style: addr/din/dout/en/re/we/wmask) between two requesters: data port D and instruction-fetch port I.
- Sits between CoreNSCSCC's memory stages and the base-RAM wrapper, so loads and stores to base RAM and instruction fetch can use the same chip.
- Sequences each access over a fixed number of SRAM cycles, returns read data, and arbitrates with D priority plus a starvation guard for I.

---
 rtl/nscscc_mem_pkg.sv | 16 +
 rtl/sram_arb_pick.sv | 22 ++
 rtl/sram_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nscscc_mem_pkg.sv
// Shared definitions for the NSCSCC memory slice: arbiter states, requester IDs
// and the base-RAM geometry.
package nscscc_mem_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   localparam logic REQ_D = 1'b0;
   localparam logic REQ_I = 1'b1;

   localparam int SRAM_ADDR_W = 20;
   localparam int SRAM_DATA_W = 32;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision for the shared SRAM port: the data port wins unless the
// instruction port has been passed over STARVE_LIMIT times in a row.
module sram_arb_pick #(
   parameter  int STARVE_LIMIT = 4,
   localparam int STV_W        = $clog2(STARVE_LIMIT + 1)
) (
   input  logic             d_valid,
   input  logic             i_valid,
   input  logic [STV_W-1:0] starve_cnt,
   output logic             grant_d,
   output logic             grant_i
);

   localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

   logic i_starved_s;

   assign i_starved_s = i_valid & (starve_cnt == STV_MAX);
   assign grant_d     = d_valid & ~i_starved_s;
   assign grant_i     = i_valid & ~grant_d;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester front end for the base-RAM wrapper: accepts one D or I access,
// holds the SRAM signals for ACCESS_CYCLES cycles and pulses the owner's response.
module sram_port_arbiter
   import nscscc_mem_pkg::*;
#(
   parameter int ADDR_W        = SRAM_ADDR_W,
   parameter int DATA_W        = SRAM_DATA_W,
   parameter int ACCESS_CYCLES = 2,
   parameter int STARVE_LIMIT  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic                d_req_we,
   input  logic [DATA_W/8-1:0] d_req_wmask,
   output logic                d_resp_valid,
   output logic [DATA_W-1:0]   d_resp_rdata,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   input  logic [DATA_W-1:0]   i_req_wdata,
   input  logic                i_req_we,
   input  logic [DATA_W/8-1:0] i_req_wmask,
   output logic                i_resp_valid,
   output logic [DATA_W-1:0]   i_resp_rdata,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_din,
   input  logic [DATA_W-1:0]   sram_dout,
   output logic                sram_en,
   output logic                sram_re,
   output logic                sram_we,
   output logic [DATA_W/8-1:0] sram_wmask,
   output logic                grant_id
);

   localparam int MASK_W = DATA_W / 8;
   localparam int ACC_W  = $clog2(ACCESS_CYCLES + 1);
   localparam int STV_W  = $clog2(STARVE_LIMIT + 1);

   localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCESS_CYCLES - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   arb_state_e          state_r;
   logic [ACC_W-1:0]    acc_cnt_r;
   logic [STV_W-1:0]    starve_cnt_r;
   logic                sram_en_r;
   logic                sram_re_r;
   logic                sram_we_r;
   logic [ADDR_W-1:0]   sram_addr_r;
   logic [DATA_W-1:0]   sram_din_r;
   logic [MASK_W-1:0]   sram_wmask_r;
   logic                grant_id_r;
   logic                d_resp_valid_r;
   logic                i_resp_valid_r;
   logic [DATA_W-1:0]   d_rdata_r;
   logic [DATA_W-1:0]   i_rdata_r;

   logic                grant_d_s;
   logic                grant_i_s;
   logic                idle_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic                sel_we_s;
   logic [MASK_W-1:0]   sel_mask_s;

   sram_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .d_valid    (d_req_valid),
      .i_valid    (i_req_valid),
      .starve_cnt (starve_cnt_r),
      .grant_d    (grant_d_s),
      .grant_i    (grant_i_s)
   );

   assign idle_s      = (state_r == IDLE);
   assign d_req_ready = idle_s & grant_d_s;
   assign i_req_ready = idle_s & grant_i_s;

   // Payload mux for the winning requester; reads drive a full-word mask.
   always_comb begin
      sel_addr_s  = d_req_addr;
      sel_wdata_s = d_req_wdata;
      sel_we_s    = d_req_we;
      sel_mask_s  = d_req_wmask;
      if (grant_i_s) begin
         sel_addr_s  = i_req_addr;
         sel_wdata_s = i_req_wdata;
         sel_we_s    = i_req_we;
         sel_mask_s  = i_req_wmask;
      end else begin
         sel_addr_s  = d_req_addr;
      end
      if (!sel_we_s) begin
         sel_mask_s = {MASK_W{1'b1}};
      end else begin
         sel_mask_s = sel_mask_s;
      end
   end

   // Access sequencer: acceptance, SRAM hold window, read capture and response pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r        <= IDLE;
         acc_cnt_r      <= {ACC_W{1'b0}};
         starve_cnt_r   <= {STV_W{1'b0}};
         sram_en_r      <= 1'b0;
         sram_re_r      <= 1'b0;
         sram_we_r      <= 1'b0;
         sram_addr_r    <= {ADDR_W{1'b0}};
         sram_din_r     <= {DATA_W{1'b0}};
         sram_wmask_r   <= {MASK_W{1'b0}};
         grant_id_r     <= 1'b0;
         d_resp_valid_r <= 1'b0;
         i_resp_valid_r <= 1'b0;
         d_rdata_r      <= {DATA_W{1'b0}};
         i_rdata_r      <= {DATA_W{1'b0}};
      end else begin
         d_resp_valid_r <= 1'b0;
         i_resp_valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (grant_d_s || grant_i_s) begin
                  state_r      <= ACCESS;
                  acc_cnt_r    <= {ACC_W{1'b0}};
                  sram_en_r    <= 1'b1;
                  sram_re_r    <= ~sel_we_s;
                  sram_we_r    <= sel_we_s;
                  sram_addr_r  <= sel_addr_s;
                  sram_din_r   <= sel_wdata_s;
                  sram_wmask_r <= sel_mask_s;
                  grant_id_r   <= grant_i_s ? REQ_I : REQ_D;
                  // I being passed over counts toward the guard; otherwise it restarts.
                  if (grant_d_s && i_req_valid) begin
                     if (starve_cnt_r != STV_MAX) begin
                        starve_cnt_r <= starve_cnt_r + {{(STV_W-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     starve_cnt_r <= {STV_W{1'b0}};
                  end
               end
            end
            ACCESS: begin
               if (acc_cnt_r == ACC_LAST) begin
                  state_r   <= IDLE;
                  sram_en_r <= 1'b0;
                  sram_re_r <= 1'b0;
                  sram_we_r <= 1'b0;
                  if (grant_id_r == REQ_I) begin
                     i_resp_valid_r <= 1'b1;
                     if (!sram_we_r) begin
                        i_rdata_r <= sram_dout;
                     end
                  end else begin
                     d_resp_valid_r <= 1'b1;
                     if (!sram_we_r) begin
                        d_rdata_r <= sram_dout;
                     end
                  end
               end else begin
                  acc_cnt_r <= acc_cnt_r + {{(ACC_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r   <= IDLE;
               sram_en_r <= 1'b0;
               sram_re_r <= 1'b0;
               sram_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign sram_en      = sram_en_r;
   assign sram_re      = sram_re_r;
   assign sram_we      = sram_we_r;
   assign sram_addr    = sram_addr_r;
   assign sram_din     = sram_din_r;
   assign sram_wmask   = sram_wmask_r;
   assign grant_id     = grant_id_r;
   assign d_resp_valid = d_resp_valid_r;
   assign i_resp_valid = i_resp_valid_r;
   assign d_resp_rdata = d_rdata_r;
   assign i_resp_rdata = i_rdata_r;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with ACCESS_CYCLES=2, STARVE_LIMIT=4.
// Inputs change and outputs are sampled 1-2 ns after the rising edge.
module tb_sram_port_arbiter;

   logic        clock;
   logic        reset;
   logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid;
   logic [19:0] d_req_addr;
   logic [31:0] d_req_wdata, d_resp_rdata;
   logic [3:0]  d_req_wmask;
   logic        i_req_valid, i_req_ready, i_req_we, i_resp_valid;
   logic [19:0] i_req_addr;
   logic [31:0] i_req_wdata, i_resp_rdata;
   logic [3:0]  i_req_wmask;
   logic [19:0] sram_addr;
   logic [31:0] sram_din, sram_dout;
   logic        sram_en, sram_re, sram_we, grant_id;
   logic [3:0]  sram_wmask;

   int n_checks;
   int n_fail;

   sram_port_arbiter #(
      .ADDR_W (20), .DATA_W (32), .ACCESS_CYCLES (2), .STARVE_LIMIT (4)
   ) dut (
      .clock (clock), .reset (reset),
      .d_req_valid (d_req_valid), .d_req_ready (d_req_ready), .d_req_addr (d_req_addr),
      .d_req_wdata (d_req_wdata), .d_req_we (d_req_we), .d_req_wmask (d_req_wmask),
      .d_resp_valid (d_resp_valid), .d_resp_rdata (d_resp_rdata),
      .i_req_valid (i_req_valid), .i_req_ready (i_req_ready), .i_req_addr (i_req_addr),
      .i_req_wdata (i_req_wdata), .i_req_we (i_req_we), .i_req_wmask (i_req_wmask),
      .i_resp_valid (i_resp_valid), .i_resp_rdata (i_resp_rdata),
      .sram_addr (sram_addr), .sram_din (sram_din), .sram_dout (sram_dout),
      .sram_en (sram_en), .sram_re (sram_re), .sram_we (sram_we),
      .sram_wmask (sram_wmask), .grant_id (grant_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({d_req_ready, i_req_ready, d_resp_valid, i_resp_valid, sram_en, sram_re, sram_we, grant_id} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {d_req_ready, i_req_ready, d_resp_valid, i_resp_valid, sram_en, sram_re, sram_we, grant_id});
      end
      n_checks++;
      if ({sram_addr, sram_din, sram_wmask, d_resp_rdata, i_resp_rdata} !== 120'h0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h din=%h mask=%h drd=%h ird=%h expected all zero",
                  sram_addr, sram_din, sram_wmask, d_resp_rdata, i_resp_rdata);
      end
      tick();
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      d_req_valid = 1'b1; d_req_addr = 20'h00010; d_req_we = 1'b0; d_req_wmask = 4'h0;
      sram_dout = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({d_req_ready, i_req_ready} !== 2'b10) begin
         n_fail++; $display("FAIL rd_ready: got %b expected 10", {d_req_ready, i_req_ready});
      end
      tick();
      d_req_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if ({sram_en, sram_re, sram_we, sram_wmask, sram_addr, grant_id, d_resp_valid} !== {3'b110, 4'hF, 20'h00010, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rd_access%0d: got en=%b re=%b we=%b mask=%h addr=%h gid=%b rv=%b expected 1 1 0 f 00010 0 0",
                     c, sram_en, sram_re, sram_we, sram_wmask, sram_addr, grant_id, d_resp_valid);
         end
         tick();
      end
      n_checks++;
      if ({sram_en, d_resp_valid, i_resp_valid, d_resp_rdata} !== {3'b010, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL rd_resp: got en=%b drv=%b irv=%b rdata=%h expected 0 1 0 deadbeef",
                  sram_en, d_resp_valid, i_resp_valid, d_resp_rdata);
      end
      tick();
      n_checks++;
      if ({d_resp_valid, d_resp_rdata} !== {1'b0, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL rd_after: got rv=%b rdata=%h expected 0 deadbeef", d_resp_valid, d_resp_rdata);
      end
   endtask

   task automatic test_byte_write();
      i_req_valid = 1'b1; i_req_addr = 20'h00004; i_req_we = 1'b1;
      i_req_wdata = 32'h12345678; i_req_wmask = 4'h2;
      sram_dout = 32'h55AA55AA;
      #1;
      n_checks++;
      if ({d_req_ready, i_req_ready} !== 2'b01) begin
         n_fail++; $display("FAIL wr_ready: got %b expected 01", {d_req_ready, i_req_ready});
      end
      tick();
      i_req_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if ({sram_en, sram_re, sram_we, sram_wmask, sram_addr, sram_din, grant_id} !== {3'b101, 4'h2, 20'h00004, 32'h12345678, 1'b1}) begin
            n_fail++;
            $display("FAIL wr_access%0d: got en=%b re=%b we=%b mask=%h addr=%h din=%h gid=%b expected 1 0 1 2 00004 12345678 1",
                     c, sram_en, sram_re, sram_we, sram_wmask, sram_addr, sram_din, grant_id);
         end
         tick();
      end
      n_checks++;
      if ({sram_en, sram_we, i_resp_valid, d_resp_valid, grant_id, i_resp_rdata} !== {5'b00101, 32'h0}) begin
         n_fail++;
         $display("FAIL wr_resp: got en=%b we=%b irv=%b drv=%b gid=%b ird=%h expected 0 0 1 0 1 00000000",
                  sram_en, sram_we, i_resp_valid, d_resp_valid, grant_id, i_resp_rdata);
      end
      tick();
      n_checks++;
      if (i_resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL wr_pulse: got irv=%b expected 0", i_resp_valid);
      end
   endtask

   task automatic test_simultaneous();
      d_req_valid = 1'b1; d_req_addr = 20'h00100; d_req_we = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 20'h00200; i_req_we = 1'b0;
      sram_dout = 32'h11111111;
      #1;
      n_checks++;
      if ({d_req_ready, i_req_ready} !== 2'b10) begin
         n_fail++; $display("FAIL sim_first: got %b expected 10", {d_req_ready, i_req_ready});
      end
      tick();
      d_req_valid = 1'b0;
      n_checks++;
      if ({grant_id, sram_addr} !== {1'b0, 20'h00100}) begin
         n_fail++; $display("FAIL sim_d_owner: got gid=%b addr=%h expected 0 00100", grant_id, sram_addr);
      end
      tick(); tick();
      sram_dout = 32'h22222222;
      #1;
      n_checks++;
      if ({d_resp_valid, d_resp_rdata, i_req_ready, sram_en} !== {1'b1, 32'h11111111, 2'b10}) begin
         n_fail++;
         $display("FAIL sim_d_resp: got drv=%b drd=%h irdy=%b en=%b expected 1 11111111 1 0",
                  d_resp_valid, d_resp_rdata, i_req_ready, sram_en);
      end
      tick();
      i_req_valid = 1'b0;
      n_checks++;
      if ({grant_id, sram_addr, sram_en} !== {1'b1, 20'h00200, 1'b1}) begin
         n_fail++; $display("FAIL sim_i_owner: got gid=%b addr=%h en=%b expected 1 00200 1", grant_id, sram_addr, sram_en);
      end
      tick(); tick();
      n_checks++;
      if ({i_resp_valid, d_resp_valid, i_resp_rdata} !== {2'b10, 32'h22222222}) begin
         n_fail++;
         $display("FAIL sim_i_resp: got irv=%b drv=%b ird=%h expected 1 0 22222222", i_resp_valid, d_resp_valid, i_resp_rdata);
      end
      tick();
   endtask

   task automatic test_starvation();
      int n_grant;
      logic exp_i;
      n_grant = 0;
      d_req_valid = 1'b1; d_req_addr = 20'h00300; d_req_we = 1'b0;
      i_req_valid = 1'b1; i_req_addr = 20'h00400; i_req_we = 1'b0;
      for (int c = 0; c < 100 && n_grant < 10; c++) begin
         #1;
         if (d_req_ready || i_req_ready) begin
            exp_i = (n_grant % 5 == 4);
            n_checks++;
            if ({d_req_ready, i_req_ready} !== {~exp_i, exp_i}) begin
               n_fail++;
               $display("FAIL starve_grant%0d: got d=%b i=%b expected d=%b i=%b",
                        n_grant, d_req_ready, i_req_ready, ~exp_i, exp_i);
            end
            n_grant++;
         end
         tick();
      end
      n_checks++;
      if (n_grant != 10) begin
         n_fail++; $display("FAIL starve_count: got %0d grants expected 10", n_grant);
      end
      d_req_valid = 1'b0; i_req_valid = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_back_to_back();
      d_req_valid = 1'b1; d_req_addr = 20'h00030; d_req_we = 1'b0;
      sram_dout = 32'h0BADF00D;
      tick();
      d_req_valid = 1'b0;
      tick(); tick();
      d_req_valid = 1'b1; d_req_addr = 20'h00031;
      #1;
      n_checks++;
      if ({d_resp_valid, d_req_ready, sram_en, sram_re, sram_we} !== 5'b11000) begin
         n_fail++;
         $display("FAIL b2b_turn: got rv=%b rdy=%b en=%b re=%b we=%b expected 1 1 0 0 0",
                  d_resp_valid, d_req_ready, sram_en, sram_re, sram_we);
      end
      tick();
      d_req_valid = 1'b0;
      sram_dout = 32'h600DCAFE;
      n_checks++;
      if ({sram_en, sram_addr, d_resp_valid} !== {1'b1, 20'h00031, 1'b0}) begin
         n_fail++; $display("FAIL b2b_second: got en=%b addr=%h rv=%b expected 1 00031 0", sram_en, sram_addr, d_resp_valid);
      end
      tick(); tick();
      n_checks++;
      if ({d_resp_valid, d_resp_rdata} !== {1'b1, 32'h600DCAFE}) begin
         n_fail++; $display("FAIL b2b_resp: got rv=%b rdata=%h expected 1 600dcafe", d_resp_valid, d_resp_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid_access();
      logic saw_resp;
      saw_resp = 1'b0;
      d_req_valid = 1'b1; d_req_addr = 20'h00050; d_req_we = 1'b0;
      sram_dout = 32'h13572468;
      tick();
      d_req_valid = 1'b0;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({sram_en, sram_re, d_resp_valid, d_resp_rdata} !== {3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL rst_mid: got en=%b re=%b rv=%b rdata=%h expected 0 0 0 00000000",
                  sram_en, sram_re, d_resp_valid, d_resp_rdata);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         if (d_resp_valid || i_resp_valid) saw_resp = 1'b1;
         if (c == 1) reset = 1'b1;
      end
      n_checks++;
      if (saw_resp !== 1'b0) begin
         n_fail++; $display("FAIL rst_noresp: got resp pulse=%b expected 0", saw_resp);
      end
      d_req_valid = 1'b1; d_req_addr = 20'h00060;
      sram_dout = 32'hCAFEF00D;
      tick();
      d_req_valid = 1'b0;
      tick(); tick();
      n_checks++;
      if ({d_resp_valid, d_resp_rdata} !== {1'b1, 32'hCAFEF00D}) begin
         n_fail++; $display("FAIL rst_recover: got rv=%b rdata=%h expected 1 cafef00d", d_resp_valid, d_resp_rdata);
      end
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0;
      d_req_valid = 1'b0; d_req_addr = 20'h0; d_req_wdata = 32'h0; d_req_we = 1'b0; d_req_wmask = 4'h0;
      i_req_valid = 1'b0; i_req_addr = 20'h0; i_req_wdata = 32'h0; i_req_we = 1'b0; i_req_wmask = 4'h0;
      sram_dout = 32'h0;
      test_reset();
      tick();
      test_single_read();
      test_byte_write();
      test_simultaneous();
      test_starvation();
      test_back_to_back();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
